// File: rtl/eig_cond_seq_if.sv
// Handshake and data bus between the eigen-decomposition engine and the
// conditioning stage. The stage itself connects through the slave modport.
interface eig_cond_seq_if #(
  parameter int N = 4,
  parameter int W = 64
);
  logic                 start_eig;
  logic [N*N*W-1:0]     E_flat;
  logic [N*W-1:0]       D_diag;
  logic [N*N*W-1:0]     E_T_flat;
  logic [N*N*W-1:0]     D_inv_sqrt_flat;
  logic [N-1:0]         err_eig;
  logic                 busy_eig;
  logic                 done_eig;

  modport master (
    output start_eig, E_flat, D_diag,
    input  E_T_flat, D_inv_sqrt_flat, err_eig, busy_eig, done_eig
  );

  modport slave (
    input  start_eig, E_flat, D_diag,
    output E_T_flat, D_inv_sqrt_flat, err_eig, busy_eig, done_eig
  );
endinterface

// File: rtl/eig_cond_seq.sv
// Eigen-conditioning stage: registers E transposed and computes diag(D^-1/2)
// with a single shared bit-serial inverse square root, one result bit per
// cycle, W-1 cycles per channel regardless of the eigenvalue.
//
//   state | meaning
//   IDLE  | waiting for start_eig; outputs hold the last published run
//   ITER  | resolving bit b of channel ch; outputs still hold the previous run
module eig_cond_seq #(
  parameter int N = 4,
  parameter int W = 64,
  parameter int F = 32
) (
  input logic          CLK_eig,
  input logic          RST_eig,
  eig_cond_seq_if.slave eig
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(W);
  localparam logic [BW-1:0]    B_TOP   = BW'(W - 2);
  localparam logic [CW-1:0]    CH_LAST = CW'(N - 1);
  localparam logic [W-1:0]     SAT     = {1'b0, {(W-1){1'b1}}};
  // 2^(3F): the trial r is accepted while r*r*D stays at or below this
  localparam logic [3*W-1:0]   LIMIT   = {{(3*W-1){1'b0}}, 1'b1} << (3*F);

  typedef enum logic {IDLE, ITER} state_t;

  state_t state_q, state_d;
  logic   busy_q, busy_d, done_q, done_d;
  logic   accept, bit_last, publish;

  logic [CW-1:0]       ch_q;
  logic [BW-1:0]       b_q;
  logic [W-1:0]        r_q;
  logic signed [W-1:0] d_cap [N];
  logic [W-1:0]        res_q [N];
  logic [N-1:0]        err_slot_q;
  logic [N*N*W-1:0]    e_t_q;
  logic [N*N*W-1:0]    d_inv_q;
  logic [N-1:0]        err_q;

  // Non-positive eigenvalues are masked to zero so the multiplier never sees
  // a sign-extended operand; their result is overridden below anyway.
  logic signed [W-1:0] dc;
  logic [W-1:0]        dc_mag;
  logic [W-1:0]        t;
  logic [3*W-1:0]      prod;
  logic [W-1:0]        r_next;
  logic [W-1:0]        ch_res;
  logic                ch_err;

  assign dc     = d_cap[ch_q];
  assign dc_mag = (dc > 0) ? dc : '0;
  assign t      = r_q | (W'(1) << b_q);
  assign prod   = (3*W)'(t) * (3*W)'(t) * (3*W)'(dc_mag);
  assign r_next = (prod <= LIMIT) ? t : r_q;
  assign ch_err = (dc <= 0);
  assign ch_res = (dc < 0) ? '0 : ((dc == 0) ? SAT : r_next);

  // State, busy and done registers
  always_ff @(posedge CLK_eig) begin
    if (RST_eig) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and handshake outputs; start is ignored outside IDLE
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    bit_last = 1'b0;
    publish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (eig.start_eig) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (b_q == '0) begin
          bit_last = 1'b1;
          if (ch_q == CH_LAST) begin
            publish = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture, bit iteration, per-channel result slots and publish
  always_ff @(posedge CLK_eig) begin
    if (RST_eig) begin
      ch_q       <= '0;
      b_q        <= '0;
      r_q        <= '0;
      err_slot_q <= '0;
      e_t_q      <= '0;
      d_inv_q    <= '0;
      err_q      <= '0;
      for (int k = 0; k < N; k++) begin
        d_cap[k] <= '0;
        res_q[k] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          e_t_q[(i*N+j)*W +: W] <= eig.E_flat[(j*N+i)*W +: W];
      for (int k = 0; k < N; k++)
        d_cap[k] <= eig.D_diag[k*W +: W];
      ch_q <= '0;
      r_q  <= '0;
      b_q  <= B_TOP;
    end else if (state_q == ITER) begin
      if (!bit_last) begin
        r_q <= r_next;
        b_q <= b_q - BW'(1);
      end else begin
        res_q[ch_q]      <= ch_res;
        err_slot_q[ch_q] <= ch_err;
        if (!publish) begin
          ch_q <= ch_q + CW'(1);
          r_q  <= '0;
          b_q  <= B_TOP;
        end else begin
          // last channel's result is still combinational on this edge
          for (int k = 0; k < N; k++) begin
            d_inv_q[(k*N+k)*W +: W] <= (k == N-1) ? ch_res : res_q[k];
            err_q[k]                <= (k == N-1) ? ch_err : err_slot_q[k];
          end
        end
      end
    end
  end

  assign eig.E_T_flat        = e_t_q;
  assign eig.D_inv_sqrt_flat = d_inv_q;
  assign eig.err_eig         = err_q;
  assign eig.busy_eig        = busy_q;
  assign eig.done_eig        = done_q;
endmodule

// File: tb/tb_eig_cond_seq.sv
// Bench for eig_cond_seq at default parameters: directed runs with known
// answers plus random runs checked against an arithmetic inverse-sqrt model.
module tb_eig_cond_seq;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int F   = 32;
  localparam int LAT = N * (W - 1);

  logic CLK_eig = 1'b0;
  logic RST_eig;
  always #5 CLK_eig = ~CLK_eig;

  eig_cond_seq_if #(.N(N), .W(W)) eig ();
  eig_cond_seq #(.N(N), .W(W), .F(F)) dut (.CLK_eig(CLK_eig), .RST_eig(RST_eig), .eig(eig));

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]        e_in [N][N];
  logic signed [W-1:0] d_in [N];
  logic [N*N*W-1:0]    exp_et;
  logic [N*N*W-1:0]    exp_dinv;
  logic [N-1:0]        exp_err;
  logic [W-1:0]        dir_diag [N];

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] isqrt(input logic [127:0] q);
    logic [127:0] x, y;
    if (q == 0) return 0;
    x = q;
    y = (x + 1) >> 1;
    while (y < x) begin
      x = y;
      y = (x + q / x) >> 1;
    end
    return x;
  endfunction

  // floor(2^F / sqrt(D / 2^F)) = floor(sqrt(2^(3F) / D)), saturated to max positive
  function automatic logic [W-1:0] ref_inv(input logic signed [W-1:0] d);
    logic [127:0] q, x;
    if (d < 0) return '0;
    if (d == 0) return {1'b0, {(W-1){1'b1}}};
    q = (128'd1 << (3*F)) / {64'd0, d};
    x = isqrt(q);
    if (x > 128'h7FFF_FFFF_FFFF_FFFF) return {1'b0, {(W-1){1'b1}}};
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom};
  endfunction

  function automatic logic signed [W-1:0] rand_d();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = {1'b1, 63'(rand_w())};
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'($urandom_range(1, 1000));
      4: v = {1'b0, 63'(rand_w())};
      default: v = 64'($urandom) << $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  // Entered on a negedge. Pulses start at the given edge numbers (0 = none).
  task automatic run(input int pa, input int pb, input int pc);
    int cyc, viol;
    logic [N*N*W-1:0] new_et;
    for (int i = 0; i < N; i++) begin
      eig.D_diag[i*W +: W] = d_in[i];
      for (int j = 0; j < N; j++) begin
        eig.E_flat[(i*N+j)*W +: W] = e_in[i][j];
        new_et[(i*N+j)*W +: W]     = e_in[j][i];
      end
    end
    eig.start_eig = 1'b1;
    @(negedge CLK_eig);
    eig.start_eig = 1'b0;
    eig.E_flat    = {N*N{rand_w()}};
    eig.D_diag    = {N{rand_w()}};
    check_eq("busy_after_start", W'(eig.busy_eig), W'(1));
    check_eq("done_after_start", W'(eig.done_eig), W'(0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check_eq($sformatf("et_%0d_%0d", i, j), eig.E_T_flat[(i*N+j)*W +: W], e_in[j][i]);
    exp_et = new_et;
    cyc  = 0;
    viol = 0;
    if (eig.D_inv_sqrt_flat !== exp_dinv || eig.err_eig !== exp_err) viol++;
    while (!eig.done_eig && cyc < LAT + 50) begin
      eig.start_eig = (cyc + 1 == pa) || (cyc + 1 == pb) || (cyc + 1 == pc);
      @(negedge CLK_eig);
      cyc++;
      if (!eig.done_eig &&
          (eig.D_inv_sqrt_flat !== exp_dinv || eig.err_eig !== exp_err ||
           eig.E_T_flat !== exp_et || eig.busy_eig !== 1'b1)) viol++;
    end
    eig.start_eig = 1'b0;
    check_eq("latency", W'(cyc), W'(LAT));
    check_eq("hold_during_iter", W'(viol), W'(0));
    check_eq("busy_at_done", W'(eig.busy_eig), W'(0));
    for (int i = 0; i < N; i++) begin
      exp_err[i] = (d_in[i] <= 0);
      for (int j = 0; j < N; j++) begin
        exp_dinv[(i*N+j)*W +: W] = (i == j) ? ref_inv(d_in[i]) : '0;
        check_eq($sformatf("dinv_%0d_%0d", i, j), eig.D_inv_sqrt_flat[(i*N+j)*W +: W],
                 exp_dinv[(i*N+j)*W +: W]);
      end
    end
    check_eq("err", W'(eig.err_eig), W'(exp_err));
    check_eq("et_stable", W'(eig.E_T_flat == exp_et), W'(1));
  endtask

  task automatic check_idle_after_done();
    @(negedge CLK_eig);
    check_eq("done_one_cycle", W'(eig.done_eig), W'(0));
    check_eq("busy_idle", W'(eig.busy_eig), W'(0));
  endtask

  task automatic check_directed(input string tag);
    for (int k = 0; k < N; k++)
      check_eq($sformatf("%s_diag%0d", tag, k), eig.D_inv_sqrt_flat[(k*N+k)*W +: W], dir_diag[k]);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      d_in[i] = rand_d();
      for (int j = 0; j < N; j++) e_in[i][j] = rand_w();
    end
  endtask

  initial begin
    int seen_done, seen_busy, nz;
    RST_eig       = 1'b1;
    eig.start_eig = 1'b0;
    eig.E_flat    = '0;
    eig.D_diag    = '0;
    exp_et        = '0;
    exp_dinv      = '0;
    exp_err       = '0;
    repeat (2) @(negedge CLK_eig);
    RST_eig = 1'b0;

    seen_done = 0; seen_busy = 0; nz = 0;
    repeat (10) begin
      @(negedge CLK_eig);
      if (eig.done_eig) seen_done++;
      if (eig.busy_eig) seen_busy++;
      if (eig.E_T_flat != 0 || eig.D_inv_sqrt_flat != 0 || eig.err_eig != 0) nz++;
    end
    check_eq("idle_done", W'(seen_done), W'(0));
    check_eq("idle_busy", W'(seen_busy), W'(0));
    check_eq("idle_outputs_zero", W'(nz), W'(0));

    // nominal: D = {1.0, 4.0, 0.25, 2.0}
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) e_in[i][j] = W'(16*i + j);
    d_in[0] = 64'h1_0000_0000; d_in[1] = 64'h4_0000_0000;
    d_in[2] = 64'h4000_0000;   d_in[3] = 64'h2_0000_0000;
    run(0, 0, 0);
    dir_diag[0] = 64'h1_0000_0000; dir_diag[1] = 64'h8000_0000;
    dir_diag[2] = 64'h2_0000_0000; dir_diag[3] = 64'hB504_F333;
    check_directed("nominal");
    check_eq("nominal_err", W'(eig.err_eig), W'(0));
    check_idle_after_done();

    // error channels: D = {0, -1.0, 2^-32, 1.0}
    d_in[0] = 64'd0; d_in[1] = -64'sh1_0000_0000;
    d_in[2] = 64'd1; d_in[3] = 64'h1_0000_0000;
    run(0, 0, 0);
    dir_diag[0] = 64'h7FFF_FFFF_FFFF_FFFF; dir_diag[1] = 64'h0;
    dir_diag[2] = 64'h1_0000_0000_0000;    dir_diag[3] = 64'h1_0000_0000;
    check_directed("errch");
    check_eq("errch_err", W'(eig.err_eig), W'(4'b0011));
    check_idle_after_done();

    // ignored starts mid-run and on the publish edge, then back-to-back run
    randomize_inputs();
    run(5, 50, LAT);
    randomize_inputs();
    run(0, 0, 0);
    check_idle_after_done();

    // reset at cycle 100 of a run
    randomize_inputs();
    for (int i = 0; i < N; i++) begin
      eig.D_diag[i*W +: W] = d_in[i];
      for (int j = 0; j < N; j++) eig.E_flat[(i*N+j)*W +: W] = e_in[i][j];
    end
    eig.start_eig = 1'b1;
    @(negedge CLK_eig);
    eig.start_eig = 1'b0;
    repeat (99) @(negedge CLK_eig);
    RST_eig = 1'b1;
    @(negedge CLK_eig);
    RST_eig = 1'b0;
    check_eq("rst_mid_busy", W'(eig.busy_eig), W'(0));
    check_eq("rst_mid_done", W'(eig.done_eig), W'(0));
    check_eq("rst_mid_outputs", W'(eig.E_T_flat != 0 || eig.D_inv_sqrt_flat != 0 || eig.err_eig != 0), W'(0));
    exp_et = '0; exp_dinv = '0; exp_err = '0;
    @(negedge CLK_eig);
    check_eq("rst_mid_idle", W'(eig.busy_eig), W'(0));
    run(0, 0, 0);
    check_idle_after_done();

    // random runs against the model
    repeat (8) begin
      randomize_inputs();
      run(($urandom_range(0, 1) == 1) ? $urandom_range(1, LAT) : 0, 0, 0);
      if ($urandom_range(0, 1) == 1) check_idle_after_done();
    end
    check_idle_after_done();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/eig_cond_seq.md
Name: eig_cond_seq

Overview:
- Parametrised successor to the fixed 4x4 eigen-conditioning stage in the whitening path, sitting between the eigen-decomposition engine and the whitening-matrix multiplier.
- Captures an NxN eigenvector matrix E and its N eigenvalues, and outputs E transposed.
- Computes the diagonal of D^-1/2 in signed fixed point using one shared bit-serial inverse-square-root datapath, so no divider or sqrt instances are needed.
- Adds a start/busy/done handshake, per-channel error flags for non-positive eigenvalues, and deterministic latency.

Parameters:
- N, 4, channel count: matrix dimension and number of eigenvalues (N >= 1).
- W, 64, word width of every element, signed two's complement.
- F, 32, fractional bits (Q(W-F).F); F < W-1.

Ports:
- CLK_eig  in  1  clock, rising edge.
- RST_eig  in  1  synchronous, active-high reset.
- start_eig  in  1  one-cycle request; sampled only in IDLE.
- E_flat  in  N*N*W  E row-major; element (i,j) at bits [(i*N+j)*W +: W].
- D_diag  in  N*W  eigenvalue k at bits [k*W +: W]; off-diagonal D is not an input.
- E_T_flat  out  N*N*W  transpose of E, same packing as E_flat.
- D_inv_sqrt_flat  out  N*N*W  full NxN matrix; diagonal (k,k) = 1/sqrt(D_k), all off-diagonal elements 0.
- err_eig  out  N  bit k set if D_k <= 0.
- busy_eig  out  1  high while iterating.
- done_eig  out  1  one-cycle pulse when the outputs are updated.

Behaviour:
- Reset: state=IDLE. All outputs, internal result registers, the channel index and the bit index are cleared to 0. Reset takes priority over every other input, including mid-operation; the results of an interrupted run are discarded.
- FSM states: IDLE, ITER.
- IDLE, start_eig=1:
  - register E_T(i,j) <= E(j,i) for all i,j;
  - capture D_diag into an internal copy;
  - ch <= 0, r <= 0, bit index b <= W-2;
  - busy_eig <= 1; go to ITER.
  - E_T_flat updates on this same edge. Inputs may change after this edge.
- IDLE, start_eig=0: hold all outputs.
- ITER, one bit per cycle for the current channel ch:
  - trial t = r | (1<<b);
  - if t*t*Dc <= 2^(3F), then r <= t; Dc is the captured D_ch.
  - Compute the product at 3W bits unsigned with no truncation; Dc is treated as unsigned only when Dc > 0.
- End of a channel (b==0): the channel result is written to slot ch:
  - Dc < 0: result 0, err[ch]=1.
  - Dc == 0: result 2^(W-1)-1 (saturated max positive), err[ch]=1.
  - otherwise: result = final r, err[ch]=0. This equals floor(sqrt(2^(3F)/Dc)), i.e. floor(2^F/sqrt(Dc/2^F)); it saturates naturally at 2^(W-1)-1.
  - Special-case channels still take the full W-1 cycles, so latency is fixed.
- Next channel: if ch < N-1, then ch++, r <= 0, b <= W-2.
- Publish (ch == N-1 at b==0):
  - the diagonal outputs and err_eig are loaded from the result slots on the same edge;
  - done_eig <= 1, busy_eig <= 0, go to IDLE;
  - done_eig clears on the following edge.
- Latency: the edge sampling start_eig is edge 0. done_eig and the new D_inv_sqrt/err are visible after edge N*(W-1). This is 252 cycles for the defaults.
- Output stability: D_inv_sqrt_flat and err_eig hold their previous-run values throughout ITER. They change only on the publish edge or on reset. E_T_flat changes only on a start-accept edge or on reset.
- start_eig during ITER, including on the publish edge, is ignored; it is not queued.
- start_eig in the IDLE cycle right after done_eig is accepted normally, giving back-to-back runs.
- No divide-by-zero or X-propagation is permitted for any D value, including the most negative value.

Test Plan:
- Reset/idle: assert RST_eig for 2 cycles, then start_eig=0 for 10 cycles -> all outputs 0, busy_eig=0, done_eig never asserted.
- Nominal (defaults): D = {1.0, 4.0, 0.25, 2.0} (0x1_0000_0000, 0x4_0000_0000, 0x4000_0000, 0x2_0000_0000); E(i,j)=16*i+j.
  - Diagonal: 0x1_0000_0000, 0x8000_0000, 0x2_0000_0000, 0xB504_F333.
  - Off-diagonal: 0.
  - E_T(i,j)=16*j+i.
  - err_eig=0, done_eig exactly 252 cycles after the start edge, for one cycle.
- Error channels: D = {0, -1.0, 1 (2^-32), 1.0} -> diagonal {0x7FFF_FFFF_FFFF_FFFF, 0, 0x1_0000_0000_0000, 0x1_0000_0000}, err_eig=4'b0011.
- Handshake: pulse start_eig at cycles 5, 50 and 252 of a run -> all three ignored; previous-run outputs held until publish; start on the cycle after done_eig is accepted and completes in 252 cycles.
- Reset mid-run: assert RST_eig at cycle 100 of a run -> next cycle all outputs 0 and state IDLE; a subsequent start completes with correct values.
- Parametrisation: N=2, W=32, F=16, D={4.0 (0x4_0000), 0.5 (0x8000)} -> diagonal {0x8000, 0x1_6A09}, latency 62 cycles, E_T correct.
